// File: rtl/mips_mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller.
// Holds the state encodings, the opcodes the controller decodes, the
// ALU-operation / PC-source / ALU-B-select codes and the control bundle
// passed from the output decoder to the top level.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_BNE     = 4'd12,
    S_EXCEPT  = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_cond_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_outdec.sv
// Combinational state-to-control decode for the multicycle controller.
// Ports: state (current FSM state), rdy (memory handshake already folded
// with the handshake enable), ctrl (datapath control bundle).
// Every output is a pure function of state, except the FETCH IR/PC loads,
// which follow rdy so the fetch completes in the cycle memory answers.
module mips_mc_ctrl_outdec
  import mips_mc_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic               rdy,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      STATE_W'(S_FETCH): begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = rdy;
        ctrl.pc_write  = rdy;
      end
      STATE_W'(S_DECODE): ctrl.alu_src_b = SRCB_SHIMM;
      STATE_W'(S_MEMADR): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      STATE_W'(S_MEMRD): begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      STATE_W'(S_MEMWB): begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      STATE_W'(S_MEMWR): begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      STATE_W'(S_EXEC): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      STATE_W'(S_RWB): begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      STATE_W'(S_BRANCH): begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_ALUOUT;
      end
      STATE_W'(S_JUMP): begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JUMP;
      end
      STATE_W'(S_ADDI_EX): begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      STATE_W'(S_ADDI_WB): ctrl.reg_write = 1'b1;
      STATE_W'(S_BNE): begin
        ctrl.alu_src_a        = 1'b1;
        ctrl.alu_op           = ALU_SUB;
        ctrl.pc_write_cond_ne = 1'b1;
        ctrl.pc_source        = PCS_ALUOUT;
      end
      STATE_W'(S_EXCEPT): begin
        ctrl.illegal   = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_EXC;
      end
      default: ctrl.pc_source = PCS_ALU;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main-control FSM: next-state logic, state register and
// retired-instruction counter; control decode lives in mips_mc_ctrl_outdec.
// Ports: clock/rst (async active-low), opcode (IR[31:26]), mem_ready
// (memory handshake), state (exported encoding), datapath controls,
// illegal (in EXCEPT), instr_count (retired instructions, wraps).
//
// state   | meaning
// 0       | FETCH    read instruction, PC+4 (waits on memory)
// 1       | DECODE   register read, branch target calc
// 2       | MEMADR   lw/sw address calc
// 3       | MEMRD    data read (waits on memory)
// 4       | MEMWB    lw writeback
// 5       | MEMWR    data write (waits on memory)
// 6       | EXEC     R-type ALU op
// 7       | RWB      R-type writeback
// 8       | BRANCH   beq
// 9       | JUMP     j
// 10      | ADDI_EX  addi ALU op
// 11      | ADDI_WB  addi writeback
// 12      | BNE      bne
// 13      | EXCEPT   illegal opcode, load exception vector
// 14..    | unused, recovers to FETCH
module mips_mc_ctrl
  import mips_mc_pkg::*;
#(
  parameter int STATE_W       = 4,
  parameter int CNT_W         = 16,
  parameter int MEM_HANDSHAKE = 1,
  parameter int EXC_EN        = 1
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] state,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_write_cond_ne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdy;
  ctrl_t              ctrl;

  // Without the handshake every memory access completes in one cycle.
  assign rdy = mem_ready | (MEM_HANDSHAKE == 0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      STATE_W'(S_FETCH):  if (rdy) state_d = STATE_W'(S_DECODE);
      STATE_W'(S_DECODE): begin
        case (opcode)
          OP_RTYPE:     state_d = STATE_W'(S_EXEC);
          OP_LW, OP_SW: state_d = STATE_W'(S_MEMADR);
          OP_BEQ:       state_d = STATE_W'(S_BRANCH);
          OP_BNE:       state_d = STATE_W'(S_BNE);
          OP_J:         state_d = STATE_W'(S_JUMP);
          OP_ADDI:      state_d = STATE_W'(S_ADDI_EX);
          default:      state_d = (EXC_EN != 0) ? STATE_W'(S_EXCEPT)
                                                : STATE_W'(S_FETCH);
        endcase
      end
      STATE_W'(S_MEMADR):  state_d = (opcode == OP_SW) ? STATE_W'(S_MEMWR)
                                                       : STATE_W'(S_MEMRD);
      STATE_W'(S_MEMRD):   if (rdy) state_d = STATE_W'(S_MEMWB);
      STATE_W'(S_MEMWR):   if (rdy) state_d = STATE_W'(S_FETCH);
      STATE_W'(S_EXEC):    state_d = STATE_W'(S_RWB);
      STATE_W'(S_ADDI_EX): state_d = STATE_W'(S_ADDI_WB);
      default:             state_d = STATE_W'(S_FETCH);
    endcase

    // An instruction retires whenever control returns to FETCH.
    cnt_d = cnt_q;
    if ((state_d == STATE_W'(S_FETCH)) && (state_q != STATE_W'(S_FETCH)))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= STATE_W'(S_FETCH);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  mips_mc_ctrl_outdec #(.STATE_W(STATE_W)) u_outdec (
    .state (state_q),
    .rdy   (rdy),
    .ctrl  (ctrl)
  );

  assign state            = state_q;
  assign instr_count      = cnt_q;
  assign pc_write         = ctrl.pc_write;
  assign pc_write_cond    = ctrl.pc_write_cond;
  assign pc_write_cond_ne = ctrl.pc_write_cond_ne;
  assign iord             = ctrl.iord;
  assign mem_read         = ctrl.mem_read;
  assign mem_write        = ctrl.mem_write;
  assign ir_write         = ctrl.ir_write;
  assign mem_to_reg       = ctrl.mem_to_reg;
  assign reg_dst          = ctrl.reg_dst;
  assign reg_write        = ctrl.reg_write;
  assign alu_src_a        = ctrl.alu_src_a;
  assign alu_src_b        = ctrl.alu_src_b;
  assign alu_op           = ctrl.alu_op;
  assign pc_source        = ctrl.pc_source;
  assign illegal          = ctrl.illegal;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl. Two instances: #0 with defaults (handshake and
// exceptions on, 16-bit counter), #1 with handshake and exceptions off and
// a 2-bit counter. Expected behaviour comes from per-opcode state paths and
// a state-to-controls table taken from the instruction-level description.
module tb_mips_mc_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]       rst_v;
  logic [1:0]       mrdy;
  logic [1:0][5:0]  opc;
  logic [1:0][3:0]  st;
  logic [1:0][15:0] cnt;
  logic [1:0][17:0] ctl;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CW = (g == 0) ? 16 : 2;
    logic [3:0]    s;
    logic [CW-1:0] c;
    logic pw, pwc, pwn, io, mr, mw, irw, m2r, rd, rw, sa, il;
    logic [1:0] sb, ao, ps;

    mips_mc_ctrl #(
      .STATE_W(4), .CNT_W(CW),
      .MEM_HANDSHAKE((g == 0) ? 1 : 0), .EXC_EN((g == 0) ? 1 : 0)
    ) u_dut (
      .clock(clock), .rst(rst_v[g]), .opcode(opc[g]), .mem_ready(mrdy[g]),
      .state(s), .pc_write(pw), .pc_write_cond(pwc), .pc_write_cond_ne(pwn),
      .iord(io), .mem_read(mr), .mem_write(mw), .ir_write(irw),
      .mem_to_reg(m2r), .reg_dst(rd), .reg_write(rw), .alu_src_a(sa),
      .alu_src_b(sb), .alu_op(ao), .pc_source(ps), .illegal(il),
      .instr_count(c)
    );

    assign st[g]  = s;
    assign cnt[g] = 16'(c);
    assign ctl[g] = {pw, pwc, pwn, io, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, il};
  end

  int checks = 0;
  int errors = 0;
  int cnt_exp [2];
  int path [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control values per state, packed in the same order as ctl.
  function automatic logic [17:0] exp_ctl(input int s, input bit r);
    bit pw = 0, pwc = 0, pwn = 0, io = 0, mr = 0, mw = 0;
    bit irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0, il = 0;
    logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
    case (s)
      0:  begin mr = 1; sb = 2'b01; irw = r; pw = r; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; end
      11: rw = 1;
      12: begin sa = 1; ao = 2'b01; pwn = 1; ps = 2'b01; end
      13: begin il = 1; pw = 1; ps = 2'b11; end
      default: ;
    endcase
    return {pw, pwc, pwn, io, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, il};
  endfunction

  function automatic void build_path(input logic [5:0] o, input bit exc);
    path = {0, 1};
    case (o)
      6'b000000: begin path.push_back(6); path.push_back(7); end
      6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
      6'b101011: begin path.push_back(2); path.push_back(5); end
      6'b000100: path.push_back(8);
      6'b000101: path.push_back(12);
      6'b000010: path.push_back(9);
      6'b001000: begin path.push_back(10); path.push_back(11); end
      default:   if (exc) path.push_back(13);
    endcase
  endfunction

  // One instruction on instance sel, starting in FETCH. fw/mw are wait
  // cycles in FETCH and in the data access (only meaningful with handshake).
  task automatic run_instr(input int sel, input logic [5:0] o, input int fw, input int mw);
    bit hs = (sel == 0);
    int s, w;
    bit r;
    build_path(o, hs);
    opc[sel] = o;
    foreach (path[i]) begin
      s = path[i];
      w = 0;
      if (hs && s == 0) w = fw;
      if (hs && (s == 3 || s == 5)) w = mw;
      for (int k = 0; k <= w; k++) begin
        if (hs && (s == 0 || s == 3 || s == 5)) r = (k == w);
        else r = 1'($urandom_range(0, 1));
        @(negedge clock);
        mrdy[sel] = r;
        #1;
        chk("state", 32'(st[sel]), 32'(s));
        chk("controls", 32'(ctl[sel]), 32'(exp_ctl(s, hs ? r : 1'b1)));
        chk("count", 32'(cnt[sel]), 32'(cnt_exp[sel]));
      end
    end
    cnt_exp[sel] = (cnt_exp[sel] + 1) % ((sel == 0) ? 65536 : 4);
    @(posedge clock);
    #1;
    chk("end_state", 32'(st[sel]), 32'd0);
    chk("end_count", 32'(cnt[sel]), 32'(cnt_exp[sel]));
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b000101;
      5: return 6'b000010;
      6: return 6'b001000;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    rst_v = 2'b00;
    mrdy  = 2'b00;
    opc   = '0;
    cnt_exp[0] = 0;
    cnt_exp[1] = 0;

    // Reset state of both instances.
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("rst_state0", 32'(st[0]), 32'd0);
    chk("rst_count0", 32'(cnt[0]), 32'd0);
    chk("rst_state1", 32'(st[1]), 32'd0);
    chk("rst_count1", 32'(cnt[1]), 32'd0);
    chk("rst_ctl0", 32'(ctl[0]), 32'(exp_ctl(0, 1'b0)));

    @(posedge clock);
    #1 rst_v[0] = 1'b1;

    // Instance 0: directed cases.
    run_instr(0, 6'b100011, 0, 0);            // lw
    chk("lw_count", 32'(cnt[0]), 32'd1);
    run_instr(0, 6'b101011, 0, 3);            // sw with 3 wait cycles
    run_instr(0, 6'b000000, 2, 0);            // R-type with 2 fetch waits
    run_instr(0, 6'b001000, 0, 0);            // addi
    run_instr(0, 6'b000100, 0, 0);            // beq
    run_instr(0, 6'b000101, 0, 0);            // bne
    run_instr(0, 6'b000010, 0, 0);            // j
    run_instr(0, 6'b111111, 0, 0);            // illegal
    chk("seq_count", 32'(cnt[0]), 32'd8);

    // Instance 0: randomized instructions and waits.
    for (int n = 0; n < 40; n++)
      run_instr(0, rand_op(), $urandom_range(0, 3), $urandom_range(0, 3));

    // Asynchronous reset while in MEMRD.
    opc[0] = 6'b100011;
    @(negedge clock); mrdy[0] = 1'b1;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock); mrdy[0] = 1'b0;
    #1 chk("pre_rst_state", 32'(st[0]), 32'd3);
    #2 rst_v[0] = 1'b0;
    #1;
    chk("async_rst_state", 32'(st[0]), 32'd0);
    chk("async_rst_count", 32'(cnt[0]), 32'd0);
    cnt_exp[0] = 0;
    @(negedge clock);
    rst_v[0] = 1'b1;
    mrdy[0]  = 1'b0;                           // instance 0 parks in FETCH

    // Instance 1: no handshake, no exceptions, 2-bit counter.
    @(posedge clock);
    #1 rst_v[1] = 1'b1;
    run_instr(1, 6'b111111, 0, 0);            // NOP path 0,1,0
    chk("nop_count", 32'(cnt[1]), 32'd1);
    run_instr(1, 6'b101011, 0, 0);
    run_instr(1, 6'b100011, 0, 0);
    for (int n = 0; n < 12; n++)
      run_instr(1, rand_op(), 0, 0);

    // Counter wrap: 5 instructions on a 2-bit counter.
    rst_v[1] = 1'b0;
    #1 chk("wrap_rst_count", 32'(cnt[1]), 32'd0);
    cnt_exp[1] = 0;
    #1 rst_v[1] = 1'b1;
    for (int n = 0; n < 5; n++)
      run_instr(1, rand_op(), 0, 0);
    chk("wrap_count", 32'(cnt[1]), 32'd1);
    chk("parked_state0", 32'(st[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
